// File: rtl/control_unit_pkg.sv
// Shared opcode, state and op-select definitions for the control unit.
package control_unit_pkg;

  localparam int unsigned OP_SEL_W = 13;
  localparam logic [1:0]  MOD_ILLEGAL = 2'b11;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,
    OP_CMP  = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_NOT  = 5'd8,
    OP_MOV  = 5'd9,
    OP_LSL  = 5'd10,
    OP_LSR  = 5'd11,
    OP_ASR  = 5'd12,
    OP_NOP  = 5'd13,
    OP_LD   = 5'd14,
    OP_ST   = 5'd15,
    OP_BEQ  = 5'd16,
    OP_BGT  = 5'd17,
    OP_B    = 5'd18,
    OP_CALL = 5'd19,
    OP_RET  = 5'd20
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    FETCH   = 3'd2,
    DECODE  = 3'd3,
    OPFETCH = 3'd4,
    EXA     = 3'd5,
    EXR     = 3'd6,
    WB      = 3'd7
  } state_e;

  // Undefined opcodes and illegal immediate modifiers collapse to nop.
  function automatic opcode_e effOpcode(input logic [4:0] op, input logic [1:0] modifier);
    if (modifier == MOD_ILLEGAL || op > 5'd20) return OP_NOP;
    return opcode_e'(op);
  endfunction

  function automatic logic writesRegister(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
      OP_AND, OP_OR, OP_NOT, OP_MOV, OP_LSL, OP_LSR, OP_ASR,
      OP_LD, OP_CALL: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_branch_decide.sv
// Branch resolution: decides whether the PC takes branchPC for this opcode.
module branch_decide
  import control_unit_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic       flagE,
  input  logic       flagGt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_B, OP_CALL, OP_RET: taken = 1'b1;
      OP_BEQ:                taken = flagE;
      OP_BGT:                taken = flagGt;
      default:               taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: INIT, then FETCH..WB per instruction, Moore-decoded controls.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] opcode,
  input  logic       iOrReg,
  input  logic [1:0] modifier,
  input  logic       flagE,
  input  logic       flagGt,
  output logic       ldPC,
  output logic       ldNPC,
  output logic       ldInst,
  output logic       ldDecodeInst,
  output logic       ldBrnchTarget,
  output logic       ldRegOutputData,
  output logic       clrPC,
  output logic       clrNPC,
  output logic       clrInst,
  output logic       clrDecodeInst,
  output logic       clrBrnchTarger,
  output logic       clrOutputRegData,
  output logic       clrA,
  output logic       clrB,
  output logic       clrResult,
  output logic       rstRegFile,
  output logic       rstFlag,
  output logic       wrRegister,
  output logic       isSt,
  output logic       isRet,
  output logic       ldA,
  output logic       ldB,
  output logic       ldResult,
  output logic       aluSel,
  output logic       wrFlag,
  output logic       isBranchTaken,
  output logic       isAdd,
  output logic       isSub,
  output logic       isMul,
  output logic       isDiv,
  output logic       isMod,
  output logic       isCmp,
  output logic       isAnd,
  output logic       isOr,
  output logic       isNot,
  output logic       isMov,
  output logic       isLsl,
  output logic       isLsr,
  output logic       isAsr
);

  state_e                state;
  state_e                stateNext;
  opcode_e               effOp;
  logic                  taken;
  logic                  isStOp;
  logic                  isRetOp;
  logic [OP_SEL_W-1:0]   aluOneHot;
  logic [OP_SEL_W-1:0]   opSel;

  assign effOp   = effOpcode(opcode, modifier);
  assign isStOp  = (effOp == OP_ST);
  assign isRetOp = (effOp == OP_RET);

  branch_decide uBranchDecide (
    .opcode (effOp),
    .flagE  (flagE),
    .flagGt (flagGt),
    .taken  (taken)
  );

  // Bit i of the one-hot select corresponds to ALU opcode i; memory ops reuse add.
  always_comb begin
    aluOneHot = '0;
    if (effOp <= OP_ASR)
      aluOneHot = {{(OP_SEL_W-1){1'b0}}, 1'b1} << effOp;
    else if (effOp == OP_LD || effOp == OP_ST)
      aluOneHot = {{(OP_SEL_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    stateNext = start ? INIT : IDLE;
      INIT:    stateNext = FETCH;
      FETCH:   stateNext = DECODE;
      DECODE:  stateNext = OPFETCH;
      OPFETCH: stateNext = EXA;
      EXA:     stateNext = EXR;
      EXR:     stateNext = WB;
      WB:      stateNext = start ? FETCH : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    ldPC             = 1'b0;
    ldNPC            = 1'b0;
    ldInst           = 1'b0;
    ldDecodeInst     = 1'b0;
    ldBrnchTarget    = 1'b0;
    ldRegOutputData  = 1'b0;
    clrPC            = 1'b0;
    clrNPC           = 1'b0;
    clrInst          = 1'b0;
    clrDecodeInst    = 1'b0;
    clrBrnchTarger   = 1'b0;
    clrOutputRegData = 1'b0;
    clrA             = 1'b0;
    clrB             = 1'b0;
    clrResult        = 1'b0;
    rstRegFile       = 1'b0;
    rstFlag          = 1'b0;
    wrRegister       = 1'b0;
    isSt             = 1'b0;
    isRet            = 1'b0;
    ldA              = 1'b0;
    ldB              = 1'b0;
    ldResult         = 1'b0;
    aluSel           = 1'b0;
    wrFlag           = 1'b0;
    isBranchTaken    = 1'b0;
    opSel            = '0;
    unique case (state)
      INIT: begin
        clrPC            = 1'b1;
        clrNPC           = 1'b1;
        clrInst          = 1'b1;
        clrDecodeInst    = 1'b1;
        clrBrnchTarger   = 1'b1;
        clrOutputRegData = 1'b1;
        clrA             = 1'b1;
        clrB             = 1'b1;
        clrResult        = 1'b1;
        rstRegFile       = 1'b1;
        rstFlag          = 1'b1;
      end
      FETCH: begin
        ldInst = 1'b1;
        ldNPC  = 1'b1;
      end
      DECODE: begin
        ldDecodeInst = 1'b1;
      end
      OPFETCH: begin
        ldRegOutputData = 1'b1;
        ldBrnchTarget   = 1'b1;
        isSt            = isStOp;
        isRet           = isRetOp;
      end
      EXA: begin
        ldA    = 1'b1;
        ldB    = 1'b1;
        aluSel = iOrReg;
        opSel  = aluOneHot;
        isSt   = isStOp;
        isRet  = isRetOp;
      end
      EXR: begin
        ldResult      = 1'b1;
        wrFlag        = (effOp == OP_CMP);
        aluSel        = iOrReg;
        opSel         = aluOneHot;
        isSt          = isStOp;
        isRet         = isRetOp;
        isBranchTaken = taken;
      end
      WB: begin
        ldPC          = 1'b1;
        wrRegister    = writesRegister(effOp);
        isRet         = isRetOp;
        isBranchTaken = taken;
      end
      default: ;
    endcase
  end

  assign isAdd = opSel[0];
  assign isSub = opSel[1];
  assign isMul = opSel[2];
  assign isDiv = opSel[3];
  assign isMod = opSel[4];
  assign isCmp = opSel[5];
  assign isAnd = opSel[6];
  assign isOr  = opSel[7];
  assign isNot = opSel[8];
  assign isMov = opSel[9];
  assign isLsl = opSel[10];
  assign isLsr = opSel[11];
  assign isAsr = opSel[12];

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected controls from an instruction-level model.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst, start, iOrReg, flagE, flagGt;
  logic [4:0] opcode;
  logic [1:0] modifier;
  logic ldPC, ldNPC, ldInst, ldDecodeInst, ldBrnchTarget, ldRegOutputData;
  logic clrPC, clrNPC, clrInst, clrDecodeInst, clrBrnchTarger, clrOutputRegData, clrA, clrB, clrResult;
  logic rstRegFile, rstFlag, wrRegister, isSt, isRet, ldA, ldB, ldResult, aluSel, wrFlag, isBranchTaken;
  logic isAdd, isSub, isMul, isDiv, isMod, isCmp, isAnd, isOr, isNot, isMov, isLsl, isLsr, isAsr;

  typedef struct packed {
    logic ldPC, ldNPC, ldInst, ldDecodeInst, ldBrnchTarget, ldRegOutputData;
    logic [8:0] clr;
    logic rstRegFile, rstFlag, wrRegister, isSt, isRet, ldA, ldB, ldResult, aluSel, wrFlag, isBranchTaken;
    logic [12:0] opSel;
  } outs_t;

  control_unit dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .iOrReg(iOrReg), .modifier(modifier),
    .flagE(flagE), .flagGt(flagGt),
    .ldPC(ldPC), .ldNPC(ldNPC), .ldInst(ldInst), .ldDecodeInst(ldDecodeInst),
    .ldBrnchTarget(ldBrnchTarget), .ldRegOutputData(ldRegOutputData),
    .clrPC(clrPC), .clrNPC(clrNPC), .clrInst(clrInst), .clrDecodeInst(clrDecodeInst),
    .clrBrnchTarger(clrBrnchTarger), .clrOutputRegData(clrOutputRegData),
    .clrA(clrA), .clrB(clrB), .clrResult(clrResult),
    .rstRegFile(rstRegFile), .rstFlag(rstFlag), .wrRegister(wrRegister),
    .isSt(isSt), .isRet(isRet), .ldA(ldA), .ldB(ldB), .ldResult(ldResult),
    .aluSel(aluSel), .wrFlag(wrFlag), .isBranchTaken(isBranchTaken),
    .isAdd(isAdd), .isSub(isSub), .isMul(isMul), .isDiv(isDiv), .isMod(isMod), .isCmp(isCmp),
    .isAnd(isAnd), .isOr(isOr), .isNot(isNot), .isMov(isMov), .isLsl(isLsl), .isLsr(isLsr), .isAsr(isAsr)
  );

  always #5 clk = ~clk;

  outs_t expQ[$];
  string tagQ[$];
  int    checks = 0;
  int    fails  = 0;

  // Bench-side run position: -2 idle, -1 init, 0..5 = fetch, decode, opfetch, exa, exr, wb.
  int          phase = -2;
  logic [4:0]  curOp;
  logic        curIor, curFe, curFg;
  logic [1:0]  curMod;

  function automatic outs_t model(input int ph);
    outs_t o = '0;
    int    e = (curOp > 5'd20 || curMod == 2'b11) ? 13 : int'(curOp);
    bit    taken  = (e == 18 || e == 19 || e == 20) || (e == 16 && curFe) || (e == 17 && curFg);
    bit    writes = e inside {0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 14, 19};
    bit    inAlu  = (ph == 3 || ph == 4);
    if (ph == -1) begin
      o.clr = '1; o.rstRegFile = 1'b1; o.rstFlag = 1'b1;
    end
    if (ph == 0) begin o.ldInst = 1'b1; o.ldNPC = 1'b1; end
    if (ph == 1) o.ldDecodeInst = 1'b1;
    if (ph == 2) begin o.ldRegOutputData = 1'b1; o.ldBrnchTarget = 1'b1; end
    if (ph == 3) begin o.ldA = 1'b1; o.ldB = 1'b1; end
    if (ph == 4) begin o.ldResult = 1'b1; o.wrFlag = (e == 5); end
    if (ph == 5) begin o.ldPC = 1'b1; o.wrRegister = writes; end
    if (inAlu) begin
      o.aluSel = curIor;
      if (e <= 12) o.opSel[e] = 1'b1;
      else if (e == 14 || e == 15) o.opSel[0] = 1'b1;
    end
    o.isSt          = (e == 15) && ph >= 2 && ph <= 4;
    o.isRet         = (e == 20) && ph >= 2 && ph <= 5;
    o.isBranchTaken = taken && ph >= 4;
    return o;
  endfunction

  task automatic cycle(input logic r, input logic s, input bit rstMid);
    outs_t e;
    @(posedge clk); #1;
    rst = r; start = s; opcode = curOp; iOrReg = curIor; modifier = curMod;
    flagE = curFe; flagGt = curFg;
    if (rstMid) begin
      #1 rst = 1'b1;
      e = '0;
      phase = -2;
    end else begin
      e = r ? outs_t'('0) : model(phase);
      if (r)               phase = -2;
      else if (phase == -2) phase = s ? -1 : -2;
      else if (phase == 5)  phase = s ? 0 : -2;
      else                  phase = phase + 1;
    end
    expQ.push_back(e);
    tagQ.push_back($sformatf("ph%0d_op%0d_mod%0d_r%0d", phase, curOp, curMod, rstMid));
  endtask

  task automatic startRun();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic runInstr(input logic [4:0] op, input logic ior, input logic [1:0] md,
                          input logic fe, input logic fg, input logic wbStart);
    if (phase == -2) startRun();
    curOp = op; curIor = ior; curMod = md; curFe = fe; curFg = fg;
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b0, wbStart, 1'b0);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      outs_t exp, act;
      string tag;
      exp = expQ.pop_front();
      tag = tagQ.pop_front();
      act = {ldPC, ldNPC, ldInst, ldDecodeInst, ldBrnchTarget, ldRegOutputData,
             {clrPC, clrNPC, clrInst, clrDecodeInst, clrBrnchTarger, clrOutputRegData, clrA, clrB, clrResult},
             rstRegFile, rstFlag, wrRegister, isSt, isRet, ldA, ldB, ldResult, aluSel, wrFlag, isBranchTaken,
             {isAsr, isLsr, isLsl, isMov, isNot, isOr, isAnd, isCmp, isMod, isDiv, isMul, isSub, isAdd}};
      checks++;
      if (act !== exp) begin
        fails++;
        $display("FAIL %s: actual=%h required=%h", tag, act, exp);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; iOrReg = 1'b0; modifier = '0; flagE = 1'b0; flagGt = 1'b0;
    curOp = '0; curIor = 1'b0; curMod = '0; curFe = 1'b0; curFg = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0);

    runInstr(5'd0,  1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    runInstr(5'd5,  1'b0, 2'b01, 1'b1, 1'b1, 1'b1);
    runInstr(5'd16, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    runInstr(5'd16, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
    runInstr(5'd20, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    runInstr(5'd25, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1);
    runInstr(5'd15, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    runInstr(5'd14, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
    runInstr(5'd17, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    runInstr(5'd19, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0);

    // Reset asserted mid-EXA, held with start high, then released.
    startRun();
    curOp = 5'd0; curIor = 1'b1; curMod = 2'b00;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++)
      runInstr(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0);

    @(negedge clk); #1;
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; opcode encodings are fixed constants from the shared package.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  run enable; level-sensitive.
REQ-005 opcode  in  5  decoded instruction opcode.
REQ-006 iOrReg  in  1  1 = immediate second operand.
REQ-007 modifier  in  2  immediate modifier; 2'b11 is illegal.
REQ-008 flagE, flagGt  in  1 each  stored compare flags.
REQ-009 ldPC, ldNPC, ldInst  out  1 each  fetch-stage register loads.
REQ-010 ldDecodeInst, ldBrnchTarget, ldRegOutputData  out  1 each  decode and operand-fetch loads.
REQ-011 clrPC, clrNPC, clrInst, clrDecodeInst, clrBrnchTarger, clrOutputRegData, clrA, clrB, clrResult  out  1 each  synchronous clears.
REQ-012 rstRegFile, rstFlag  out  1 each  register-file and flag clears.
REQ-013 wrRegister  out  1  register-file write enable.
REQ-014 isSt, isRet  out  1 each  operand-fetch port selects.
REQ-015 ldA, ldB, ldResult  out  1 each  ALU register loads.
REQ-016 aluSel  out  1  ALU second-operand select (1 = immediate).
REQ-017 wrFlag  out  1  flag register write.
REQ-018 isBranchTaken  out  1  PC source select (1 = branchPC).
REQ-019 isAdd, isSub, isMul, isDiv, isMod, isCmp, isAnd, isOr, isNot, isMov, isLsl, isLsr, isAsr  out  1 each  one-hot ALU op selects.

Function
REQ-020 Opcodes: add 0, sub 1, mul 2, div 3, mod 4, cmp 5, and 6, or 7, not 8, mov 9, lsl 10, lsr 11, asr 12, nop 13, ld 14, st 15, beq 16, bgt 17, b 18, call 19, ret 20.
REQ-021 Opcodes 21-31, and any opcode with modifier 2'b11, SHALL execute as nop.
REQ-022 The FSM SHALL have 3-bit state: IDLE 0, INIT 1, FETCH 2, DECODE 3, OPFETCH 4, EXA 5, EXR 6, WB 7.
REQ-023 Transitions: IDLE->INIT on start=1, otherwise stay in IDLE; INIT->FETCH->DECODE->OPFETCH->EXA->EXR->WB.
REQ-024 WB SHALL go to FETCH when start=1 and to IDLE when start=0; start=0 never aborts an instruction in progress.
REQ-025 All outputs are Moore-decoded from state plus opcode/flags; any output not listed for a state SHALL be 0.
REQ-026 INIT SHALL assert every clr*, rstRegFile and rstFlag.
REQ-027 FETCH SHALL assert ldInst and ldNPC.
REQ-028 DECODE SHALL assert ldDecodeInst.
REQ-029 OPFETCH SHALL assert ldRegOutputData and ldBrnchTarget.
REQ-030 isSt SHALL be 1 for st in OPFETCH through EXR; isRet SHALL be 1 for ret in OPFETCH through WB.
REQ-031 EXA and EXR SHALL drive the one-hot op select: ALU opcodes 0-12 map to their own select, and ld/st map to isAdd; branch and nop opcodes drive none.
REQ-032 aluSel SHALL equal iOrReg during EXA and EXR.
REQ-033 EXA SHALL assert ldA and ldB; EXR SHALL assert ldResult, plus wrFlag for cmp only.
REQ-034 isBranchTaken SHALL be 1 in EXR and WB for b, call and ret, for beq when flagE=1, and for bgt when flagGt=1.
REQ-035 WB SHALL assert ldPC for every instruction, so the PC receives branchPC when taken and NPC otherwise.
REQ-036 WB SHALL assert wrRegister for opcodes 0-4, 6-12, 14 and 19 only.
REQ-037 Throughput: one instruction per 6 cycles; the first FETCH follows start by 2 cycles.

Reset
REQ-038 rst=1 SHALL force state IDLE immediately, with all outputs 0, regardless of clk.
REQ-039 Reset mid-instruction SHALL abandon the instruction with no further writes; after rst falls, operation resumes through INIT only when start=1.

Structure
REQ-040 The opcode constants, state encodings and the one-hot op-select width (13) SHALL live in a shared package.
REQ-041 A combinational sub-module, branch_decide (opcode, flagE, flagGt -> taken), is natural; the rest is a single FSM.

Verification
REQ-042 rst pulse, start=0 for 5 cycles -> state stays IDLE and all outputs stay 0.
REQ-043 start=1, opcode=0 (add), iOrReg=1 -> INIT clears once; sequence FETCH..WB with isAdd=1 and aluSel=1 in EXA/EXR, wrRegister=1 and ldPC=1 in WB, isBranchTaken=0.
REQ-044 opcode=5 (cmp) -> wrFlag=1 only in EXR; wrRegister=0 in WB.
REQ-045 opcode=16 (beq) with flagE=1 -> isBranchTaken=1 in EXR/WB; with flagE=0 -> isBranchTaken=0 and ldPC=1.
REQ-046 opcode=20 (ret) -> isRet=1 in OPFETCH through WB and isBranchTaken=1; opcode=25 -> behaves as nop.
REQ-047 rst asserted during EXA -> state IDLE and all outputs 0 within the same cycle.
